// File: rtl/wdt_timer_if.sv
// Slave-side RIB bus bundle for the watchdog: write strobe, address, write data and read data.
interface wdt_timer_if;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output we_i, output addr_i, output data_i, input data_o);
    modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/wdt_timer.sv
// Watchdog timer: keyed kick, bark interrupt on first expiry, bite reset pulse on second.
// Optional macro WDT_WINDOW_EN adds a WINDOW register that rejects too-early kicks.
module wdt_timer #(
    parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5,
    parameter int unsigned RST_PULSE = 16,
    parameter logic [31:0] LOAD_RST  = 32'h00FF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    wdt_timer_if.slave bus,
    output logic       int_sig_o,
    output logic       rst_req_o
);
    localparam int unsigned PW     = 8;
    localparam logic [4:0]  A_CTRL = 5'h00;
    localparam logic [4:0]  A_LOAD = 5'h04;
    localparam logic [4:0]  A_CNT  = 5'h08;
    localparam logic [4:0]  A_KICK = 5'h0C;
    localparam logic [4:0]  A_WIN  = 5'h10;

    typedef enum logic [1:0] {IDLE, RUN, BARK, BITE} state_t;

    state_t        state, state_nxt;
    logic          en, int_en, rst_en, lock, pend, keyerr;
    logic          en_nxt, int_en_nxt, rst_en_nxt, lock_nxt, pend_nxt, keyerr_nxt;
    logic [31:0]   load, load_nxt, count, count_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic [4:0]    offs;
    logic [31:0]   rv, count_tick;
    logic          wr_ctrl, wr_load, wr_kick, kick_key, kick_early, expire, en_set, en_clr;
    logic          unused_addr;

    assign offs        = bus.addr_i[4:0];
    assign unused_addr = ^bus.addr_i[31:5];
    assign wr_ctrl     = bus.we_i && (offs == A_CTRL);
    assign wr_load     = bus.we_i && (offs == A_LOAD);
    assign wr_kick     = bus.we_i && (offs == A_KICK);
    assign kick_key    = wr_kick && (bus.data_i == KICK_KEY);
    assign en_set      = wr_ctrl && !lock && bus.data_i[0];
    assign en_clr      = wr_ctrl && !lock && !bus.data_i[0];
    assign rv          = (load == 32'd0) ? 32'd1 : load;
    assign expire      = (count == 32'd1);
    assign count_tick  = expire ? rv : (count - 32'd1);

`ifdef WDT_WINDOW_EN
    logic [31:0] window, window_nxt;
    logic        wr_win;
    assign wr_win     = bus.we_i && (offs == A_WIN);
    assign kick_early = kick_key && (window != 32'd0) && (count > window);
    assign window_nxt = (wr_win && !lock) ? bus.data_i : window;

    always_ff @(posedge clk) begin
        if (rst) window <= '0;
        else     window <= window_nxt;
    end
`else
    assign kick_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            en     <= 1'b0;
            int_en <= 1'b0;
            rst_en <= 1'b0;
            lock   <= 1'b0;
            pend   <= 1'b0;
            keyerr <= 1'b0;
            load   <= LOAD_RST;
            count  <= LOAD_RST;
            pcnt   <= '0;
        end else begin
            state  <= state_nxt;
            en     <= en_nxt;
            int_en <= int_en_nxt;
            rst_en <= rst_en_nxt;
            lock   <= lock_nxt;
            pend   <= pend_nxt;
            keyerr <= keyerr_nxt;
            load   <= load_nxt;
            count  <= count_nxt;
            pcnt   <= pcnt_nxt;
        end
    end

    // Register writes first, then timer events; later assignments win (bark beats W1C of pend).
    always_comb begin
        state_nxt  = state;
        en_nxt     = en;
        int_en_nxt = int_en;
        rst_en_nxt = rst_en;
        lock_nxt   = lock;
        pend_nxt   = pend;
        keyerr_nxt = keyerr;
        load_nxt   = load;
        count_nxt  = count;
        pcnt_nxt   = pcnt;

        if (wr_ctrl) begin
            if (!lock) {rst_en_nxt, int_en_nxt, en_nxt} = bus.data_i[2:0];
            lock_nxt = lock | bus.data_i[3];
            if (bus.data_i[4]) pend_nxt = 1'b0;
            if (bus.data_i[5]) keyerr_nxt = 1'b0;
        end
        if (wr_load && !lock) load_nxt = bus.data_i;
        if (wr_kick && !kick_key) keyerr_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (en_set) begin
                    count_nxt = rv;
                    state_nxt = RUN;
                end
            end
            RUN, BARK: begin
                if (en_clr) begin
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count_tick;
                    if (kick_early) keyerr_nxt = 1'b1;
                    if (kick_early && rst_en) begin
                        state_nxt = BITE;
                        pcnt_nxt  = '0;
                    end else if (kick_key && !kick_early) begin
                        count_nxt = rv;
                        pend_nxt  = 1'b0;
                        state_nxt = RUN;
                    end else if (expire) begin
                        if (state == RUN) begin
                            pend_nxt  = 1'b1;
                            state_nxt = BARK;
                        end else if (rst_en) begin
                            state_nxt = BITE;
                            pcnt_nxt  = '0;
                        end
                    end
                end
            end
            BITE: begin
                if (en_clr) begin
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count_tick;
                    pcnt_nxt  = pcnt + PW'(1);
                    if (pcnt == PW'(RST_PULSE - 1)) begin
                        state_nxt = RUN;
                        count_nxt = rv;
                        pend_nxt  = 1'b0;
                        pcnt_nxt  = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-latency read mux.
    always_comb begin
        bus.data_o = '0;
        case (offs)
            A_CTRL: bus.data_o = {26'd0, keyerr, pend, lock, rst_en, int_en, en};
            A_LOAD: bus.data_o = load;
            A_CNT:  bus.data_o = count;
`ifdef WDT_WINDOW_EN
            A_WIN:  bus.data_o = window;
`endif
            default: bus.data_o = '0;
        endcase
    end

    assign int_sig_o = pend & int_en;
    assign rst_req_o = (state == BITE);
endmodule

// File: tb/tb_wdt_timer.sv
// Self-checking bench for wdt_timer: directed timing scenarios plus random traffic
// compared cycle by cycle with a behavioural watchdog model.
module tb_wdt_timer;
    localparam logic [31:0] KEY      = 32'h5A5A_A5A5;
    localparam logic [31:0] BADKEY   = 32'h1234_5678;
    localparam logic [31:0] LOAD_RST = 32'h00FF_FFFF;
    localparam int          PULSE    = 16;
`ifdef WDT_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic int_sig;
    logic rst_req;
    int   errors = 0;
    int   checks = 0;

    wdt_timer_if bus ();

    wdt_timer dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .int_sig_o(int_sig),
        .rst_req_o(rst_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 run, 2 bark, 3 bite; bite_left counts remaining pulse cycles.
    logic        m_en, m_int_en, m_rst_en, m_lock, m_pend, m_keyerr;
    logic [31:0] m_load, m_count, m_window;
    int          m_phase, m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        {m_en, m_int_en, m_rst_en, m_lock, m_pend, m_keyerr} = '0;
        m_load   = LOAD_RST;
        m_count  = LOAD_RST;
        m_window = '0;
        m_phase  = 0;
        m_left   = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] ad);
        case (ad[4:0])
            5'h00:   return {26'd0, m_keyerr, m_pend, m_lock, m_rst_en, m_int_en, m_en};
            5'h04:   return m_load;
            5'h08:   return m_count;
            5'h10:   return WIN ? m_window : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit w, input logic [31:0] ad, input logic [31:0] d);
        logic [4:0]  o       = ad[4:0];
        bit          wc      = w && (o == 5'h00);
        bit          wk      = w && (o == 5'h0C);
        bit          good    = wk && (d == KEY);
        bit          early   = WIN && good && (m_window != 0) && (m_count > m_window);
        bit          expired = (m_count == 32'd1);
        logic [31:0] reload  = (m_load == 0) ? 32'd1 : m_load;
        logic        n_pend  = m_pend;
        logic        n_kerr  = m_keyerr;
        logic [31:0] n_count = m_count;
        int          n_phase = m_phase;
        int          n_left  = m_left;

        if (wc && d[4]) n_pend = 1'b0;
        if (wc && d[5]) n_kerr = 1'b0;
        if (wk && !good) n_kerr = 1'b1;

        if (m_phase == 0) begin
            if (wc && !m_lock && d[0]) begin
                n_phase = 1;
                n_count = reload;
            end
        end else if (wc && !m_lock && !d[0]) begin
            n_phase = 0;
        end else begin
            n_count = expired ? reload : m_count - 32'd1;
            if (m_phase == 3) begin
                n_left = m_left - 1;
                if (n_left == 0) begin
                    n_phase = 1;
                    n_count = reload;
                    n_pend  = 1'b0;
                end
            end else begin
                if (early) n_kerr = 1'b1;
                if (early && m_rst_en) begin
                    n_phase = 3;
                    n_left  = PULSE;
                end else if (good && !early) begin
                    n_count = reload;
                    n_pend  = 1'b0;
                    n_phase = 1;
                end else if (expired && m_phase == 1) begin
                    n_pend  = 1'b1;
                    n_phase = 2;
                end else if (expired && m_rst_en) begin
                    n_phase = 3;
                    n_left  = PULSE;
                end
            end
        end

        if (wc) begin
            if (!m_lock) {m_rst_en, m_int_en, m_en} = d[2:0];
            m_lock = m_lock | d[3];
        end
        if (w && o == 5'h04 && !m_lock) m_load = d;
        if (WIN && w && o == 5'h10 && !m_lock) m_window = d;
        m_pend   = n_pend;
        m_keyerr = n_kerr;
        m_count  = n_count;
        m_phase  = n_phase;
        m_left   = n_left;
    endtask

    // One bus cycle: drive at negedge, check outputs against the model, then advance both.
    task automatic tick(input bit w, input logic [31:0] ad, input logic [31:0] d);
        @(negedge clk);
        bus.we_i   = w;
        bus.addr_i = ad;
        bus.data_i = d;
        #1;
        chk("rd", bus.data_o, model_read(ad));
        chk("int", 32'(int_sig), 32'(m_int_en & m_pend));
        chk("rst_req", 32'(rst_req), 32'(m_phase == 3));
        model_step(w, ad, d);
        @(posedge clk);
    endtask

    // Directed check against fixed values just after an edge.
    task automatic probe(input string tag, input logic [31:0] ad, input logic [31:0] ed,
                         input logic ei, input logic er);
        #2;
        bus.we_i   = 1'b0;
        bus.addr_i = ad;
        #1;
        chk({tag, "_rd"}, bus.data_o, ed);
        chk({tag, "_int"}, 32'(int_sig), 32'(ei));
        chk({tag, "_rst"}, 32'(rst_req), 32'(er));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.we_i = 1'b0;
        @(posedge clk);
        model_reset();
        #1 rst = 1'b0;
    endtask

    task automatic setup10(input logic [31:0] ctrl);
        do_reset();
        tick(1'b1, 32'h04, 32'd10);
        tick(1'b1, 32'h00, ctrl);
    endtask

    initial begin
        rst        = 1'b0;
        bus.we_i   = 1'b0;
        bus.addr_i = '0;
        bus.data_i = '0;
        model_reset();

        do_reset();
        probe("rst_ctrl", 32'h00, 32'h0, 1'b0, 1'b0);
        probe("rst_load", 32'h04, LOAD_RST, 1'b0, 1'b0);
        probe("rst_count", 32'h08, LOAD_RST, 1'b0, 1'b0);

        setup10(32'h3);
        for (int c = 1; c <= 10; c++) begin
            tick(1'b0, 32'h08, 32'h0);
            if (c == 9)  probe("bark_pre", 32'h08, 32'd1, 1'b0, 1'b0);
            if (c == 10) probe("bark", 32'h08, 32'd10, 1'b1, 1'b0);
        end

        setup10(32'h7);
        for (int c = 1; c <= 40; c++) begin
            tick(1'b0, 32'h00, 32'h0);
            if (c == 19) probe("bite_pre", 32'h00, 32'h17, 1'b1, 1'b0);
            if (c == 20) probe("bite_on", 32'h00, 32'h17, 1'b1, 1'b1);
            if (c == 35) probe("bite_last", 32'h00, 32'h17, 1'b1, 1'b1);
            if (c == 36) probe("bite_off", 32'h00, 32'h07, 1'b0, 1'b0);
        end

        setup10(32'h7);
        for (int c = 1; c <= 40; c++) begin
            if (c % 8 == 0) tick(1'b1, 32'h0C, KEY);
            else            tick(1'b0, 32'h08, 32'h0);
        end
        probe("kick_period", 32'h00, 32'h07, 1'b0, 1'b0);

        setup10(32'h7);
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) tick(1'b1, 32'h0C, BADKEY);
            else        tick(1'b0, 32'h00, 32'h0);
        end
        probe("badkey", 32'h00, 32'h37, 1'b1, 1'b0);

        setup10(32'h7);
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) tick(1'b1, 32'h0C, KEY);
            else         tick(1'b0, 32'h08, 32'h0);
        end
        probe("coinc_cnt", 32'h08, 32'd10, 1'b0, 1'b0);
        probe("coinc_ctrl", 32'h00, 32'h07, 1'b0, 1'b0);

        do_reset();
        tick(1'b1, 32'h00, 32'hF);
        tick(1'b1, 32'h00, 32'h0);
        tick(1'b1, 32'h04, 32'd5);
        probe("lock_ctrl", 32'h00, 32'h0F, 1'b0, 1'b0);
        probe("lock_load", 32'h04, LOAD_RST, 1'b0, 1'b0);
        tick(1'b1, 32'h0C, BADKEY);
        probe("lock_keyerr", 32'h00, 32'h2F, 1'b0, 1'b0);
        tick(1'b1, 32'h00, 32'h30);
        probe("lock_w1c", 32'h00, 32'h0F, 1'b0, 1'b0);

`ifdef WDT_WINDOW_EN
        do_reset();
        tick(1'b1, 32'h04, 32'd100);
        tick(1'b1, 32'h10, 32'd40);
        tick(1'b1, 32'h00, 32'h7);
        for (int c = 1; c <= 40; c++) tick(1'b0, 32'h08, 32'h0);
        probe("win_cnt60", 32'h08, 32'd60, 1'b0, 1'b0);
        tick(1'b1, 32'h0C, KEY);
        probe("win_early", 32'h00, 32'h27, 1'b0, 1'b1);

        do_reset();
        tick(1'b1, 32'h04, 32'd100);
        tick(1'b1, 32'h10, 32'd40);
        tick(1'b1, 32'h00, 32'h7);
        for (int c = 1; c <= 70; c++) tick(1'b0, 32'h08, 32'h0);
        probe("win_cnt30", 32'h08, 32'd30, 1'b0, 1'b0);
        tick(1'b1, 32'h0C, KEY);
        probe("win_ok", 32'h08, 32'd100, 1'b0, 1'b0);
`endif

        // Random traffic with small reload values so bark/bite/kick races happen often.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            for (int i = 0; i < 500; i++) begin
                int          r  = int'($urandom_range(0, 15));
                logic [31:0] ad;
                logic [31:0] d  = $urandom;
                bit          w  = 1'b1;
                case ($urandom_range(0, 6))
                    0:       ad = 32'h00;
                    1:       ad = 32'h04;
                    2:       ad = 32'h08;
                    3:       ad = 32'h0C;
                    4:       ad = 32'h10;
                    5:       ad = 32'h14;
                    default: ad = $urandom;
                endcase
                case (r)
                    0: begin
                        ad = 32'h00;
                        d  = {26'd0, d[5:4], ($urandom_range(0, 15) == 0), d[2:1],
                              ($urandom_range(0, 7) != 0)};
                    end
                    1: begin ad = 32'h04; d = $urandom_range(0, 12); end
                    2: begin ad = 32'h0C; d = KEY; end
                    3: begin ad = 32'h0C; d = ($urandom_range(0, 1) == 0) ? KEY : d; end
                    4: begin ad = 32'h10; d = $urandom_range(0, 12); end
                    5: ad = $urandom;
                    default: w = 1'b0;
                endcase
                tick(w, ad, d);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wdt_timer.md
Name: wdt_timer

Overview:
- Watchdog timer peripheral on a free RIB slave port of the SoC.
- Consumes the slave-side bus signals (`addr`, `data`, `we`) that the interconnect drives.
- Produces two outputs:
  - `int_sig_o`, which goes into the core's `int_flag` vector.
  - `rst_req_o`, which is ORed into the core/JTAG reset request path.
- Two-stage timeout: first expiry raises an interrupt ("bark"); a second expiry without service raises a reset request ("bite").

Parameters:
- KICK_KEY, 32'h5A5A_A5A5, value that must be written to KICK to service the watchdog.
- RST_PULSE, 16, length of the `rst_req_o` pulse in clk cycles (valid range 1..255).
- LOAD_RST, 32'h00FF_FFFF, reset value of the LOAD register.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- we_i  in  1  bus write enable (valid in the same cycle as addr_i/data_i)
- addr_i  in  32  bus address; only addr_i[4:0] is decoded
- data_i  in  32  bus write data
- data_o  out  32  bus read data, combinational from addr_i
- int_sig_o  out  1  bark interrupt, level, = CTRL.pend & CTRL.int_en
- rst_req_o  out  1  bite reset request, active-high pulse

Behaviour:
- Reset: one clk with rst=1 sets the following.
  - CTRL=0, LOAD=LOAD_RST, COUNT=LOAD_RST, state=IDLE, pulse counter=0.
  - int_sig_o=0, rst_req_o=0.
  - data_o is a function of addr_i only.
- Register map (addr_i[4:0]):
  - 0x00 CTRL, bit fields:
    - [0] en
    - [1] int_en
    - [2] rst_en
    - [3] lock, write-1-only sticky; cleared only by rst
    - [4] pend, read-only; W1C
    - [5] keyerr, read-only; W1C
  - 0x04 LOAD: R/W.
  - 0x08 COUNT: read-only.
  - 0x0C KICK: write-only; reads return 0.
  - Unmapped offsets read 0 and ignore writes.
- Lock:
  - While lock=1, writes to CTRL[2:0] and LOAD are ignored.
  - While lock=1, W1C of pend/keyerr and writes to KICK still work.
- Writes take effect at the clk edge; reads have zero latency.
- Effective reload value RV = (LOAD==0) ? 1 : LOAD.
- States:
  - IDLE: en=0. COUNT holds its value.
    - On the write that sets en 0->1: COUNT<=RV, go to RUN.
  - RUN: COUNT decrements by 1 per cycle.
    - When COUNT==1 at an edge: COUNT<=RV, pend<=1, go to BARK.
  - BARK: COUNT decrements by 1 per cycle.
    - When COUNT==1: COUNT<=RV. If rst_en=1, go to BITE; else stay in BARK.
  - BITE: rst_req_o=1 for exactly RST_PULSE cycles, then go to RUN with COUNT=RV and pend=0.
    - The counter keeps running during BITE.
- Kick:
  - A write of KICK_KEY to 0x0C in RUN or BARK sets COUNT<=RV, pend<=0, state=RUN.
  - A write of any other value sets keyerr<=1 and does nothing else.
  - Kicks in IDLE or BITE are ignored, except that keyerr still applies.
- Clearing en (writing en=0) from any state: go to IDLE, pend unchanged, rst_req_o<=0 immediately.
- Simultaneous events:
  - A valid kick in the same cycle as expiry wins: no bark and no bite.
  - W1C of pend in the same cycle as a bark expiry: pend ends at 1.
  - A LOAD write while RUN/BARK is used at the next reload only.
- Reset during BITE: rst_req_o drops on that edge.

Optional Feature:
- Macro: WDT_WINDOW_EN.
- With the macro defined:
  - Adds register 0x10 WINDOW (R/W, lock-protected, reset 0).
  - A valid KICK while COUNT > WINDOW is a too-early kick: sets keyerr=1.
    - If rst_en=1, go directly to BITE.
    - If rst_en=0, the kick is ignored.
  - WINDOW=0 disables the check.
- Without the macro: 0x10 reads 0, writes are ignored, and every valid kick is accepted.

Test Plan:
- Reset, then read 0x00/0x04/0x08 -> CTRL=0, LOAD=0x00FF_FFFF, COUNT=0x00FF_FFFF; int_sig_o=0, rst_req_o=0.
- Bark timing: LOAD=10, CTRL=0x3, no kicks -> pend=1 and int_sig_o=1 exactly 10 cycles after the enable edge; COUNT reads 10 on that cycle.
- Bite timing: LOAD=10, CTRL=0x7, no kicks -> rst_req_o high from cycle 20 to cycle 35 (16 cycles), then state RUN, pend=0.
- Kick handling, LOAD=10, CTRL=0x7:
  - KICK=0x5A5AA5A5 every 8 cycles -> never barks.
  - KICK=0x12345678 -> keyerr=1, bark still occurs at 10.
  - Valid kick coincident with expiry -> no bark.
- Lock: CTRL=0xF, then write CTRL=0x0 and LOAD=5 -> CTRL[3:0] stays 0xF, LOAD unchanged; W1C 0x30 clears pend/keyerr.
- WDT_WINDOW_EN: LOAD=100, WINDOW=40, CTRL=0x7, valid kick at COUNT=60 -> keyerr=1, rst_req_o rises next cycle; valid kick at COUNT=30 -> COUNT reloads to 100.
